// File: rtl/bl_nibble_loader_pkg.sv
// Shared widths and defaults for the bootloader nibble loader.
// Values match the 4-bit CPU the loader feeds.
package bl_nibble_loader_pkg;

  localparam int unsigned REGISTER_WIDTH_DEF       = 4;
  localparam int unsigned MEMORY_ADDRESS_WIDTH_DEF = 4;
  localparam int unsigned MEMORY_REGISTERS_DEF     = 16;
  localparam int unsigned SYNC_STAGES_DEF          = 2;
  localparam int unsigned STATE_W                  = 3;

endpackage

// File: rtl/bl_nibble_loader_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin with rising-edge detection.
// rise_o is high for one cycle when the synchronized level goes 0 -> 1.
module sync_edge_detect
  import bl_nibble_loader_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/bl_nibble_loader.sv
// Bootloader front end: receives a 16-nibble image plus checksum over a
// strobe-qualified pin interface and writes it into the CPU's memory.
module bl_nibble_loader
  import bl_nibble_loader_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH       = REGISTER_WIDTH_DEF,
  parameter int unsigned MEMORY_ADDRESS_WIDTH = MEMORY_ADDRESS_WIDTH_DEF,
  parameter int unsigned MEMORY_REGISTERS     = MEMORY_REGISTERS_DEF,
  parameter int unsigned SYNC_STAGES          = SYNC_STAGES_DEF
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            ld_start_i,
  input  logic                            ld_strobe_i,
  input  logic [REGISTER_WIDTH-1:0]       ld_data_i,
  output logic                            bl_programm_o,
  output logic [REGISTER_WIDTH-1:0]       bl_data_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] bl_address_o,
  output logic                            bl_write_en_mem_o,
  output logic                            done_o,
  output logic                            err_o
);

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_LOAD  = 3'd1;
  localparam logic [STATE_W-1:0] S_CHECK = 3'd2;
  localparam logic [STATE_W-1:0] S_DONE  = 3'd3;
  localparam logic [STATE_W-1:0] S_ERROR = 3'd4;

  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LAST_ADDR =
    MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);

  typedef enum logic [STATE_W-1:0] {
    IDLE  = S_IDLE,
    LOAD  = S_LOAD,
    CHECK = S_CHECK,
    DONE  = S_DONE,
    ERROR = S_ERROR
  } state_t;

  state_t                          state_q;
  logic [MEMORY_ADDRESS_WIDTH-1:0] cnt_q;
  logic [REGISTER_WIDTH-1:0]       sum_q;
  logic                            strobe_rise;
  logic                            start_rise;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (ld_strobe_i),
    .rise_o  (strobe_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (ld_start_i),
    .rise_o  (start_rise)
  );

  // Load sequencer; a start edge overrides any strobe edge in the same cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      sum_q             <= '0;
      bl_programm_o     <= 1'b0;
      bl_data_o         <= '0;
      bl_address_o      <= '0;
      bl_write_en_mem_o <= 1'b0;
      done_o            <= 1'b0;
      err_o             <= 1'b0;
    end else begin
      bl_write_en_mem_o <= 1'b0;
      if (start_rise) begin
        state_q       <= LOAD;
        cnt_q         <= '0;
        sum_q         <= '0;
        done_o        <= 1'b0;
        err_o         <= 1'b0;
        bl_programm_o <= 1'b1;
      end else begin
        case (state_q)
          LOAD: begin
            if (strobe_rise) begin
              bl_data_o         <= ld_data_i;
              bl_address_o      <= cnt_q;
              bl_write_en_mem_o <= 1'b1;
              sum_q             <= sum_q + ld_data_i;
              cnt_q             <= cnt_q + MEMORY_ADDRESS_WIDTH'(1);
              if (cnt_q == LAST_ADDR) state_q <= CHECK;
            end
          end
          CHECK: begin
            if (strobe_rise) begin
              if (ld_data_i == sum_q) begin
                state_q       <= DONE;
                done_o        <= 1'b1;
                bl_programm_o <= 1'b0;
              end else begin
                state_q <= ERROR;
                err_o   <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/bl_nibble_loader.md
# bl_nibble_loader

Bootloader front end for the 4-bit CPU. It receives a 16-nibble program image plus one checksum nibble from external pins through a strobe-qualified parallel interface, and drives the CPU's bootloader port (`bl_programm_i`, `bl_data_i`, `bl_address_i`, `bl_write_en_mem_i`) to write the image into `reg_memory`. It holds the CPU in programming mode while loading. It sits beside `cpu` in the top level, between the TinyTapeout input pins and the CPU's bootloader inputs.

## Interface
Parameters:
- `REGISTER_WIDTH`, 4: data nibble width; matches the CPU.
- `MEMORY_ADDRESS_WIDTH`, 4: address width; matches the CPU.
- `MEMORY_REGISTERS`, 16: number of words per image; must equal 2^`MEMORY_ADDRESS_WIDTH`.
- `SYNC_STAGES`, 2: synchronizer depth for `ld_strobe_i` and `ld_start_i`; minimum 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  system clock, the same clock as `cpu`.
- `reset_i`  in  1  asynchronous, active-low reset.
- `ld_start_i`  in  1  asynchronous pin; a synchronized rising edge starts or restarts a load.
- `ld_strobe_i`  in  1  asynchronous pin; a synchronized rising edge captures `ld_data_i`.
- `ld_data_i`  in  `REGISTER_WIDTH`  nibble; must be stable whenever `ld_strobe_i` is high.
- `bl_programm_o`  out  1  connects to `cpu.bl_programm_i`.
- `bl_data_o`  out  `REGISTER_WIDTH`  connects to `cpu.bl_data_i`.
- `bl_address_o`  out  `MEMORY_ADDRESS_WIDTH`  connects to `cpu.bl_address_i`.
- `bl_write_en_mem_o`  out  1  connects to `cpu.bl_write_en_mem_i`; one-cycle pulse per write.
- `done_o`  out  1  image loaded and checksum matched.
- `err_o`  out  1  checksum mismatch.

## Operation
- States: IDLE, LOAD, CHECK, DONE, ERROR.
- Reset state: IDLE. All outputs are 0. Address counter, checksum accumulator and synchronizers are cleared.
- IDLE: `bl_programm_o`=0, so the CPU runs the current memory contents. A start edge moves to LOAD.
- LOAD:
  - `bl_programm_o`=1.
  - On each strobe edge, the block registers `bl_data_o`=`ld_data_i` and `bl_address_o`=counter, and pulses `bl_write_en_mem_o` for one cycle.
  - On the same edge, checksum += data (mod 2^`REGISTER_WIDTH`) and counter += 1.
  - The write to address `MEMORY_REGISTERS`-1 moves to CHECK. The counter wraps to 0.
- CHECK:
  - `bl_programm_o`=1.
  - The next strobe edge compares `ld_data_i` with the checksum. No memory write occurs.
  - Equal: go to DONE. Not equal: go to ERROR.
- DONE: `bl_programm_o`=0 and `done_o`=1. The CPU restarts from its own reset and PC handling.
- ERROR: `bl_programm_o` stays 1, holding the CPU, and `err_o`=1.
- Start edge in any state:
  - Clears the counter, checksum, `done_o` and `err_o`.
  - Enters LOAD. In LOAD or CHECK this aborts the current load.
- Start and strobe edges in the same cycle: start wins and the strobe edge is discarded.
- Strobe edges in IDLE, DONE or ERROR are ignored.
- `reset_i` low mid-load: immediate return to IDLE with `bl_programm_o`=0. The partially written memory is left as is.

## Timing
- Both async inputs pass through `SYNC_STAGES` flops. The rising edge is detected from the last stage and the stage after it.
- Let edge k be the first `clk_i` edge that samples `ld_strobe_i` high. `bl_write_en_mem_o`, `bl_data_o` and `bl_address_o` update at edge k+`SYNC_STAGES`, so the latency is `SYNC_STAGES` cycles.
- `ld_data_i` is sampled directly, without a synchronizer, at edge k+`SYNC_STAGES`.
- The external driver must hold `ld_strobe_i` high for at least `SYNC_STAGES`+1 cycles and low for at least `SYNC_STAGES`+1 cycles between strobes.
- `bl_data_o` and `bl_address_o` hold their values after each write pulse.
- The `bl_programm_o` rise on a start edge is registered, with the same latency as a strobe. It is high at least one cycle before the first write pulse.
- The DONE/ERROR transition and the `done_o`/`err_o` assertion occur at the CHECK strobe's edge k+`SYNC_STAGES`.
- All outputs are registered; no output has a combinational path from inputs.

## Structure
- State encodings are localparams in the module. Width parameters come from the same values the CPU instance uses, passed from the top level.
- One sub-module, `sync_edge_detect`:
  - Parameter `SYNC_STAGES`.
  - Ports `clk_i`, `reset_i`, async `d_i`, and `rise_o` (a one-cycle pulse).
  - Instantiated twice, once for strobe and once for start.

## Test plan
- Reset asserted with random pins, then released → all outputs 0, state IDLE; strobes ignored (no `bl_write_en_mem_o`).
- Start, then nibbles 0x1..0xF,0x0, then checksum 0x8 → 16 write pulses at addresses 0..15 with matching data; `done_o`=1; `bl_programm_o`=0; CPU memory dump equals the image.
- Same image with checksum 0x9 → `err_o`=1, `bl_programm_o` stays 1, `done_o`=0.
- Start, 5 nibbles, start again, then a full image of 0xA with checksum 0x0 → addresses restart at 0; `done_o`=1 after 16 more writes.
- `reset_i` pulled low after 7 writes → same cycle all outputs 0; after release the next load begins at address 0.
- Strobe edge coincident with a start edge in LOAD → no write; counter 0; the next strobe writes address 0.
